// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D).
// Sequences each access through a fixed read latency and returns done pulses.
//
// Ports:
//  clock, reset_n        clock, async active-low reset
//  i_req/i_addr          fetch request and address (read only)
//  i_rdata/i_done        fetch data (registered) and one-cycle completion pulse
//  d_req/d_we/d_addr     data request, 1=store, address
//  d_wdata               store data
//  d_rdata/d_done        load data (registered) and one-cycle completion pulse
//  mem_addr/mem_wdata    registered memory address and write data
//  mem_wr                memory write strobe (1 = write)
//  mem_rdata             memory read data
//  busy                  state is not IDLE
//  owner                 port of current or last grant (0 = I, 1 = D)
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_owner;
  logic              r_last;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_gnt;
  logic w_gnt_d;
  logic w_rd_cap;

  // Next state and grant decision. A grant can come from IDLE or,
  // back-to-back, from RESP when the other port is waiting.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_gnt_d     = 1'b0;
    w_rd_cap    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_gnt = 1'b1;
          // on a conflict the port that did not go last wins
          w_gnt_d = d_req && (!i_req || !r_last);
        end
      end
      S_READ: begin
        if (r_cnt == LAT) begin
          w_rd_cap    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_WRITE: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        // the owner's own req is ignored here
        if (r_owner ? i_req : d_req) begin
          w_gnt   = 1'b1;
          w_gnt_d = !r_owner;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_gnt) begin
      w_state_nxt = (w_gnt_d && d_we) ? S_WRITE : S_READ;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt) begin
        r_cnt      <= '0;
        r_owner    <= w_gnt_d;
        r_last     <= w_gnt_d;
        r_mem_addr <= w_gnt_d ? d_addr : i_addr;
        if (w_gnt_d) begin
          r_mem_wdata <= d_wdata;
        end
      end else if (r_state == S_READ && !w_rd_cap) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_rd_cap) begin
        if (r_owner) begin
          r_d_rdata <= mem_rdata;
        end else begin
          r_i_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wr    = (r_state == S_WRITE);
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_done    = (r_state == S_RESP) && !r_owner;
  assign d_done    = (r_state == S_RESP) && r_owner;

  a_done_excl: assert property (
    @(posedge clock) disable iff (!reset_n) !(i_done && d_done));

  a_wr_single: assert property (
    @(posedge clock) disable iff (!reset_n) mem_wr |=> !mem_wr);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Two instances: READ_LATENCY=2 (main) and READ_LATENCY=1 (load after store).
module tb_mem_port_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        a_i_req, a_d_req, a_d_we;
  logic [31:0] a_i_addr, a_d_addr, a_d_wdata;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_i_done, a_d_done, a_mem_wr, a_busy, a_owner;

  logic        b_i_req, b_d_req, b_d_we;
  logic [31:0] b_i_addr, b_d_addr, b_d_wdata;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_i_done, b_d_done, b_mem_wr, b_busy, b_owner;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .READ_LATENCY(2)
  ) u_a (
    .clock(clk), .reset_n(rst_n),
    .i_req(a_i_req), .i_addr(a_i_addr),
    .i_rdata(a_i_rdata), .i_done(a_i_done),
    .d_req(a_d_req), .d_we(a_d_we),
    .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_done(a_d_done),
    .mem_addr(a_mem_addr), .mem_wr(a_mem_wr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)
  ) u_b (
    .clock(clk), .reset_n(rst_n),
    .i_req(b_i_req), .i_addr(b_i_addr),
    .i_rdata(b_i_rdata), .i_done(b_i_done),
    .d_req(b_d_req), .d_we(b_d_we),
    .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_done(b_d_done),
    .mem_addr(b_mem_addr), .mem_wr(b_mem_wr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .owner(b_owner)
  );

  // memory models: read pipeline of READ_LATENCY edges
  bit   [31:0] mem_a [256];
  bit   [31:0] mem_b [256];
  logic [31:0] a_p0, a_p1, b_p0;

  always @(posedge clk) begin
    a_p0 <= mem_a[a_mem_addr[9:2]];
    a_p1 <= a_p0;
    if (a_mem_wr) mem_a[a_mem_addr[9:2]] = a_mem_wdata;
  end

  always @(posedge clk) begin
    b_p0 <= mem_b[b_mem_addr[9:2]];
    if (b_mem_wr) mem_b[b_mem_addr[9:2]] = b_mem_wdata;
  end

  assign a_mem_rdata = a_p1;
  assign b_mem_rdata = b_p0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_i_req = 0; a_d_req = 0; a_d_we = 0;
    a_i_addr = 0; a_d_addr = 0; a_d_wdata = 0;
    b_i_req = 0; b_d_req = 0; b_d_we = 0;
    b_i_addr = 0; b_d_addr = 0; b_d_wdata = 0;
    #12;
    total++;
    if ({a_busy, a_mem_wr, a_i_done, a_d_done, a_owner,
         a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b wr=%b idn=%b ddn=%b own=%b ird=%h drd=%h ma=%h mw=%h required all 0",
               a_busy, a_mem_wr, a_i_done, a_d_done, a_owner,
               a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata);
    end
    #6 rst_n = 1'b1;
    tick();
    total++;
    if (a_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b required 0", a_busy);
    end
  endtask

  task automatic test_fetch();
    exp_t e;
    sb.push_back('{1'b0, 32'h8C220000, 4});
    a_i_addr = 32'h4;
    a_i_req  = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n == 1) begin
        total++;
        if (a_mem_addr !== 32'h4) begin
          bad++;
          $display("FAIL fetch_addr got=%h required=%h", a_mem_addr, 32'h4);
        end
      end
      total++;
      if (a_busy !== 1'(n <= 4)) begin
        bad++;
        $display("FAIL fetch_busy cyc=%0d got=%b required=%b", n, a_busy, n <= 4);
      end
      total++;
      if (a_i_done !== 1'(n == 4)) begin
        bad++;
        $display("FAIL fetch_done cyc=%0d got=%b required=%b", n, a_i_done, n == 4);
      end
      if (a_i_done && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (a_i_rdata !== e.data || n != e.cyc) begin
          bad++;
          $display("FAIL fetch_data got=%h@%0d required=%h@%0d", a_i_rdata, n, e.data, e.cyc);
        end
        a_i_req = 1'b0;
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL fetch_missing got=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_store();
    exp_t e;
    sb.push_back('{1'b1, a_d_rdata, 2});
    a_d_addr  = 32'h40;
    a_d_wdata = 32'hDEADBEEF;
    a_d_we    = 1'b1;
    a_d_req   = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      total++;
      if (a_mem_wr !== 1'(n == 1)) begin
        bad++;
        $display("FAIL store_wr cyc=%0d got=%b required=%b", n, a_mem_wr, n == 1);
      end
      if (n == 1) begin
        total++;
        if (a_mem_addr !== 32'h40 || a_mem_wdata !== 32'hDEADBEEF) begin
          bad++;
          $display("FAIL store_bus got=%h/%h required=00000040/deadbeef", a_mem_addr, a_mem_wdata);
        end
      end
      total++;
      if (a_d_done !== 1'(n == 2)) begin
        bad++;
        $display("FAIL store_done cyc=%0d got=%b required=%b", n, a_d_done, n == 2);
      end
      if (a_d_done && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (a_d_rdata !== e.data || n != e.cyc) begin
          bad++;
          $display("FAIL store_rdata got=%h@%0d required=%h@%0d", a_d_rdata, n, e.data, e.cyc);
        end
        a_d_req = 1'b0;
        a_d_we  = 1'b0;
      end
    end
    total++;
    if (sb.size() != 0 || mem_a[16] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL store_mem got=%h pending=%0d required=deadbeef pending=0", mem_a[16], sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_abort();
    a_i_addr = 32'h4;
    a_i_req  = 1'b1;
    tick();
    tick();
    total++;
    if (a_busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre got busy=%b required 1", a_busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_busy, a_mem_wr, a_i_done, a_d_done, a_owner} !== 5'b0 ||
        a_i_rdata !== '0 || a_d_rdata !== '0) begin
      bad++;
      $display("FAIL abort_read got busy=%b wr=%b idn=%b ddn=%b own=%b ird=%h drd=%h required all 0",
               a_busy, a_mem_wr, a_i_done, a_d_done, a_owner, a_i_rdata, a_d_rdata);
    end
    a_i_req = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (a_busy !== 1'b0 || a_i_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got busy=%b done=%b required 0/0", a_busy, a_i_done);
    end
    a_d_addr  = 32'h44;
    a_d_wdata = 32'h1;
    a_d_we    = 1'b1;
    a_d_req   = 1'b1;
    tick();
    total++;
    if (a_mem_wr !== 1'b1) begin
      bad++;
      $display("FAIL abort_wr_pre got=%b required=1", a_mem_wr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (a_mem_wr !== 1'b0 || a_d_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_wr got wr=%b done=%b required 0/0", a_mem_wr, a_d_done);
    end
    a_d_req = 1'b0;
    a_d_we  = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (a_busy !== 1'b0 || a_d_done !== 1'b0 || mem_a[17] !== 32'h0) begin
      bad++;
      $display("FAIL abort_wr_idle got busy=%b done=%b mem=%h required 0/0/0", a_busy, a_d_done, mem_a[17]);
    end
  endtask

  task automatic test_conflict();
    exp_t        e;
    logic        gp;
    logic [31:0] gd;
    bit          got;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        a_i_addr = 32'h4;
        a_i_req  = 1'b1;
        got = 0;
        for (int n = 1; n <= 8 && !got; n++) begin
          tick();
          if (a_i_done) got = 1;
        end
        a_i_req = 1'b0;
        total++;
        if (!got) begin
          bad++;
          $display("FAIL conflict_lone got no done required done within 8");
        end
        tick();
      end
      sb.push_back('{r == 1, (r == 1) ? 32'hDEADBEEF : 32'h8C220000, 4});
      sb.push_back('{r == 0, (r == 1) ? 32'h8C220000 : 32'hDEADBEEF, 8});
      a_i_addr = 32'h4;
      a_d_addr = 32'h40;
      a_d_we   = 1'b0;
      a_i_req  = 1'b1;
      a_d_req  = 1'b1;
      for (int n = 1; n <= 10; n++) begin
        tick();
        if (n == 1) begin
          total++;
          if (a_owner !== 1'(r == 1)) begin
            bad++;
            $display("FAIL conflict_first r=%0d got=%b required=%b", r, a_owner, r == 1);
          end
        end
        if (n == 5) begin
          total++;
          if (a_busy !== 1'b1 || a_owner !== 1'(r == 0)) begin
            bad++;
            $display("FAIL conflict_b2b r=%0d got busy=%b own=%b required 1/%b", r, a_busy, a_owner, r == 0);
          end
        end
        total++;
        if (a_i_done && a_d_done) begin
          bad++;
          $display("FAIL conflict_both_done cyc=%0d got=11 required not both", n);
        end
        if (a_i_done || a_d_done) begin
          gp = a_d_done;
          gd = a_d_done ? a_d_rdata : a_i_rdata;
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL conflict_extra cyc=%0d got port=%b required none", n, gp);
          end else begin
            e = sb.pop_front();
            if (gp !== e.port || gd !== e.data || n != e.cyc) begin
              bad++;
              $display("FAIL conflict_resp got p%b %h@%0d required p%b %h@%0d",
                       gp, gd, n, e.port, e.data, e.cyc);
            end
          end
          if (gp) a_d_req = 1'b0;
          else    a_i_req = 1'b0;
        end
      end
      a_i_req = 1'b0;
      a_d_req = 1'b0;
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL conflict_missing r=%0d got=%0d pending required=0", r, sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_held_req();
    exp_t e;
    sb.push_back('{1'b0, 32'h8C220000, 4});
    sb.push_back('{1'b0, 32'hDEADBEEF, 9});
    a_i_addr = 32'h4;
    a_i_req  = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 5 || n == 6) begin
        total++;
        if (a_busy !== 1'(n == 6)) begin
          bad++;
          $display("FAIL held_busy cyc=%0d got=%b required=%b", n, a_busy, n == 6);
        end
      end
      total++;
      if (a_d_done !== 1'b0) begin
        bad++;
        $display("FAIL held_ddone cyc=%0d got=1 required=0", n);
      end
      if (a_i_done) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL held_extra cyc=%0d got done required none", n);
        end else begin
          e = sb.pop_front();
          if (a_i_rdata !== e.data || n != e.cyc) begin
            bad++;
            $display("FAIL held_resp got %h@%0d required %h@%0d", a_i_rdata, n, e.data, e.cyc);
          end
        end
        if (sb.size() == 0) a_i_req = 1'b0;
        else a_i_addr = 32'h40;
      end
    end
    a_i_req = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL held_missing got=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_load_after_store();
    exp_t e;
    b_d_addr  = 32'h80;
    b_d_wdata = 32'h12345678;
    b_d_we    = 1'b1;
    b_d_req   = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      total++;
      if (b_mem_wr !== 1'(n == 1) || b_d_done !== 1'(n == 2)) begin
        bad++;
        $display("FAIL l1_store cyc=%0d got wr=%b done=%b required %b/%b",
                 n, b_mem_wr, b_d_done, n == 1, n == 2);
      end
      if (b_d_done) begin
        b_d_req = 1'b0;
        b_d_we  = 1'b0;
      end
    end
    sb.push_back('{1'b1, 32'h12345678, 3});
    b_d_req = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      total++;
      if (b_d_done !== 1'(n == 3) || b_i_done !== 1'b0) begin
        bad++;
        $display("FAIL l1_load_done cyc=%0d got d=%b i=%b required %b/0", n, b_d_done, b_i_done, n == 3);
      end
      if (b_d_done && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (b_d_rdata !== e.data || n != e.cyc) begin
          bad++;
          $display("FAIL l1_load_data got %h@%0d required %h@%0d", b_d_rdata, n, e.data, e.cyc);
        end
        b_d_req = 1'b0;
      end
    end
    b_d_req = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL l1_missing got=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    mem_a[1] = 32'h8C220000;
    test_reset();
    test_fetch();
    test_store();
    test_reset_abort();
    test_conflict();
    test_held_req();
    test_load_after_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
